// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered
// Serial receive front end for an 8N1 UART. The asynchronous rx pin is
// synchronised and a falling edge starts a frame. The start bit is
// re-checked at mid-bit. Eight data bits are then sampled LSB first and
// the stop bit is checked. Good bytes are stored in a small show-ahead
// FIFO, which the CPU-side register logic drains.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx_en        receiver enable; dropping it mid-frame aborts the frame
//   rx           serial line, asynchronous, idle high
//   rd_en        single-cycle pulse that pops the FIFO head
//   clr_err      clears the sticky overrun / frame_err flags
//   rx_data      FIFO head byte, 0x00 when empty
//   receive_flag FIFO not empty
//   overrun      sticky: a good byte was dropped because the FIFO was full
//   frame_err    sticky: a stop bit was sampled low
//   busy         receiver state is not IDLE

module uart_rx_buffered #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_en,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       receive_flag,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [11:0] HALF_M1 = 12'(CLKS_PER_BIT / 2 - 1);
    localparam logic [11:0] FULL_M1 = 12'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    logic        rx_meta_q, rx_s_q, rx_d_q;
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic        fifo_empty, fifo_full;
    logic        push, pop, set_ovr, set_ferr;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Two-flop synchroniser for the pin, plus one delayed copy for edge detect.
    // All three idle high so a reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    // Receive state machine: next state, bit timing, shift register and
    // the push / error decisions taken at the stop-bit sample.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push     = 1'b0;
        set_ovr  = 1'b0;
        set_ferr = 1'b0;

        if (state_q != IDLE && !rx_en) begin
            // Abort: drop the partial byte, leave FIFO and flags alone.
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Edge-triggered so a line held low cannot retrigger.
                    if (rx_en && rx_d_q && !rx_s_q) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        shift_d[idx_q] = rx_s_q;
                        cnt_d          = '0;
                        idx_d          = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        if (rx_s_q) begin
                            // A pop in the same cycle frees the slot on a full FIFO.
                            if (!fifo_full || rd_en) begin
                                push = 1'b1;
                            end else begin
                                set_ovr = 1'b1;
                            end
                        end else begin
                            set_ferr = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // FIFO pointer update and sticky flags. A set beats a simultaneous clear.
    always_comb begin
        pop         = rd_en && !fifo_empty;
        wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
        overrun_d   = set_ovr  | (overrun_q   & ~clr_err);
        frame_err_d = set_ferr | (frame_err_q & ~clr_err);
        busy_d      = (state_d != IDLE);
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // FIFO storage needs no reset: the output is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    assign rx_data      = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q[AW-1:0]];
    assign receive_flag = !fifo_empty;
    assign overrun      = overrun_q;
    assign frame_err    = frame_err_q;
    assign busy         = busy_q;

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Serial receive front end for the 50 MHz UART: 8N1 at 115200 bps. It synchronises the asynchronous `rx` pin, detects and validates the start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. Good bytes go into a small show-ahead FIFO that the CPU-side register logic drains. It sits between the board pin and the UART register interface, and it produces the `rx_data` / `receive_flag` pair the UART top exposes.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 434: clocks per bit (50 MHz / 115200, rounded). Legal range 16..4095.
- `FIFO_DEPTH`, default 4: receive FIFO entries. Power of two, 2..16.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_en`  in  1  receiver enable.
- `rx`  in  1  serial line, asynchronous, idle high.
- `rd_en`  in  1  pop FIFO head. Single-cycle pulse.
- `clr_err`  in  1  clears the sticky error flags.
- `rx_data`  out  8  FIFO head byte (show-ahead). 0x00 when empty.
- `receive_flag`  out  1  FIFO not empty.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `busy`  out  1  state is not IDLE.

## Operation

- **Synchroniser.** `rx` passes through two flops to give `rx_s`. A third flop gives `rx_d`. All three reset to 1.
- **IDLE.**
  - Falling edge (`rx_d`=1, `rx_s`=0) with `rx_en`=1 moves to START and clears the counter.
  - A line held low does not re-trigger reception.
- **START.**
  - The counter runs to `CLKS_PER_BIT/2 - 1` (integer divide).
  - At that point, `rx_s`=0 moves to DATA with counter=0 and bit index=0.
  - At that point, `rx_s`=1 is a glitch: return to IDLE, with no flag and no push.
- **DATA.**
  - Each time the counter reaches `CLKS_PER_BIT - 1`, `rx_s` is shifted into bit[index] (LSB first), the counter clears and the index increments.
  - After index 7, move to STOP.
- **STOP.** When the counter reaches `CLKS_PER_BIT - 1`, `rx_s` is sampled.
  - Sample = 1, FIFO not full: push the byte.
  - Sample = 1, FIFO full and no `rd_en` this cycle: drop the byte and set `overrun`.
  - Sample = 0: discard the byte and set `frame_err`.
  - All three cases return to IDLE in the next cycle.
- **rx_en deasserted mid-frame.** Abort to IDLE on the next clock. The partial byte is discarded. FIFO contents and flags are kept.
- **FIFO.**
  - Circular buffer with read/write pointers one bit wider than the address. Pointers wrap modulo 2·`FIFO_DEPTH`.
  - Empty: pointers equal.
  - Full: MSBs differ and the rest are equal.
- **rd_en.**
  - On an empty FIFO: ignored. Pointer unchanged, no error.
  - Together with a push on a full FIFO: the pop and the push both complete, and `overrun` is not set.
- **Error flags.**
  - `clr_err` clears both flags.
  - If a set and a clear happen in the same cycle, set wins.

## Timing

- **Reset values.**
  - State IDLE; counter, index and shift register 0.
  - FIFO empty; `rx_data`=0x00.
  - `receive_flag`=0, `overrun`=0, `frame_err`=0, `busy`=0.
- **Sample points.** Measured in clocks after the cycle that detects the edge:
  - Start check at `CLKS_PER_BIT/2`.
  - Data bit k at `CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT`.
  - Stop bit at `CLKS_PER_BIT/2 + 9·CLKS_PER_BIT`.
  - Pin-to-detect adds 2 clocks of synchroniser latency.
- **Push latency.** The push registers on the stop-sample clock. `receive_flag` and `rx_data` are valid on the next clock edge.
- **Pop latency.** `rd_en` sampled high at edge N: the pointer advances at N, and the new head and `receive_flag` are valid after N.
- **busy.** Rises the clock after edge detect. Falls the clock after the stop sample, glitch reject, or abort.
- **Back-to-back frames.** A falling edge arriving 1 clock after return to IDLE is accepted. The block adds no inter-frame gap.

## Test plan

1. **Basic receive.** Reset, `rx_en`=1, send 0x55 at 434 clk/bit.
   - Expect `receive_flag`=1 and `rx_data`=0x55 one clock after the stop sample.
   - Pulse `rd_en`: expect `receive_flag`=0 and `rx_data`=0x00.
2. **Overrun and order.** Send 0xA5, 0x3C, 0x00, 0xFF, 0x81 back-to-back with no reads (depth 4).
   - Expect `overrun`=1.
   - Reads return A5, 3C, 00, FF, then `receive_flag`=0.
   - `clr_err` then gives `overrun`=0.
3. **Framing error.** Send 0x96 with the stop bit driven low.
   - Expect `frame_err`=1 and no push.
   - The line stays low for 2 bit times with no new frame.
   - After the line returns high, 0x12 is received correctly.
4. **Glitch reject.** Drive `rx` low for 100 clocks, then high.
   - Expect a return to IDLE at the start check, `busy` back to 0, and no flags set.
5. **Full FIFO with simultaneous pop.** Fill 4 bytes, then pulse `rd_en` on the stop-sample clock of a 5th byte 0x7E.
   - Expect `overrun`=0 and the FIFO holding bytes 2, 3, 4 and 0x7E.
6. **Reset and enable mid-frame.**
   - Assert `rst_n`=0 during data bit 3: all outputs return to reset values immediately.
   - Deassert `rx_en` during bit 5 of another frame: abort, and the FIFO is unchanged.
